// File: rtl/conv2d_sequencer.sv
// ---------------------------------------------------------------------------
// conv2d_sequencer
//
// Purpose:
//   Walks a complete 2-D convolution over externally held input, weight and
//   bias memories. Every output element takes one bias read, one tap per MAC
//   cycle, a drain cycle for the last product and a write cycle. The block
//   therefore spends IC*K*K+3 cycles on each output.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous, active-low reset
//   start        begin one full convolution (sampled only while idle)
//   busy         job in progress (BIAS, MAC, DRAIN, WRITE)
//   done         one-cycle completion pulse
//   in_rd_en     input memory read enable
//   in_addr      input memory address
//   in_rd_data   input data, valid one cycle after the read
//   w_rd_en      weight memory read enable
//   w_addr       weight memory address
//   w_rd_data    weight data, one-cycle latency
//   b_rd_en      bias memory read enable
//   b_addr       bias memory address
//   b_rd_data    bias data, one-cycle latency
//   out_wr_en    result write enable
//   out_addr     result address
//   out_wr_data  result data
//
// Build option:
//   CONV2D_SEQ_RELU_EN  when defined, negative results are written as zero.
// ---------------------------------------------------------------------------
module conv2d_sequencer #(
    parameter int DATA_WIDTH   = 32,
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int KERNEL_SIZE  = 3,
    parameter int STRIDE       = 1,
    parameter int PADDING      = 0,
    localparam int OUT_HEIGHT  = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
    localparam int OUT_WIDTH   = (IN_WIDTH + 2*PADDING - KERNEL_SIZE) / STRIDE + 1,
    localparam int IN_ELEMS    = BATCH_SIZE * IN_CHANNELS * IN_HEIGHT * IN_WIDTH,
    localparam int W_ELEMS     = OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    localparam int B_ELEMS     = OUT_CHANNELS,
    localparam int OUT_ELEMS   = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
    localparam int IN_AW       = (IN_ELEMS  > 1) ? $clog2(IN_ELEMS)  : 1,
    localparam int W_AW        = (W_ELEMS   > 1) ? $clog2(W_ELEMS)   : 1,
    localparam int B_AW        = (B_ELEMS   > 1) ? $clog2(B_ELEMS)   : 1,
    localparam int OUT_AW      = (OUT_ELEMS > 1) ? $clog2(OUT_ELEMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  in_rd_en,
    output logic [IN_AW-1:0]      in_addr,
    input  logic [DATA_WIDTH-1:0] in_rd_data,
    output logic                  w_rd_en,
    output logic [W_AW-1:0]       w_addr,
    input  logic [DATA_WIDTH-1:0] w_rd_data,
    output logic                  b_rd_en,
    output logic [B_AW-1:0]       b_addr,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  out_wr_en,
    output logic [OUT_AW-1:0]     out_addr,
    output logic [DATA_WIDTH-1:0] out_wr_data
);

    localparam int CW = 16;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t B_LAST  = cnt_t'(BATCH_SIZE - 1);
    localparam cnt_t OC_LAST = cnt_t'(OUT_CHANNELS - 1);
    localparam cnt_t OY_LAST = cnt_t'(OUT_HEIGHT - 1);
    localparam cnt_t OX_LAST = cnt_t'(OUT_WIDTH - 1);
    localparam cnt_t C_LAST  = cnt_t'(IN_CHANNELS - 1);
    localparam cnt_t K_LAST  = cnt_t'(KERNEL_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    cnt_t                  b_q, b_d, oc_q, oc_d, oy_q, oy_d, ox_q, ox_d;
    cnt_t                  c_q, c_d, ky_q, ky_d, kx_q, kx_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  tap_valid_q, tap_valid_d;

    int                    iy, ix;
    logic                  tap_in_bounds;
    logic [DATA_WIDTH-1:0] prev_prod;
    logic [DATA_WIDTH-1:0] result;

    // Tap coordinates in the (unpadded) input plane; negative or oversized
    // values fall in the zero padding border.
    always_comb begin
        iy = int'(oy_q) * STRIDE + int'(ky_q) - PADDING;
        ix = int'(ox_q) * STRIDE + int'(kx_q) - PADDING;
        tap_in_bounds = (iy >= 0) && (iy < IN_HEIGHT) && (ix >= 0) && (ix < IN_WIDTH);
    end

    // The product arriving this cycle belongs to the tap issued last cycle.
    // A padding tap never read memory, so its stale read data is masked off.
    always_comb begin
        prev_prod = '0;
        if (tap_valid_q) begin
            prev_prod = in_rd_data * w_rd_data;
        end
    end

    always_comb begin
`ifdef CONV2D_SEQ_RELU_EN
        result = acc_q[DATA_WIDTH-1] ? '0 : acc_q;
`else
        result = acc_q;
`endif
    end

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        oc_d        = oc_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        c_d         = c_q;
        ky_d        = ky_q;
        kx_d        = kx_q;
        acc_d       = acc_q;
        tap_valid_d = 1'b0;

        busy        = 1'b0;
        done        = 1'b0;
        in_rd_en    = 1'b0;
        in_addr     = '0;
        w_rd_en     = 1'b0;
        w_addr      = '0;
        b_rd_en     = 1'b0;
        b_addr      = '0;
        out_wr_en   = 1'b0;
        out_addr    = '0;
        out_wr_data = '0;

        unique case (state_q)
            IDLE: begin
                b_d  = '0;
                oc_d = '0;
                oy_d = '0;
                ox_d = '0;
                c_d  = '0;
                ky_d = '0;
                kx_d = '0;
                if (start) begin
                    state_d = BIAS;
                end
            end

            BIAS: begin
                busy    = 1'b1;
                b_rd_en = 1'b1;
                b_addr  = B_AW'(oc_q);
                state_d = MAC;
            end

            MAC: begin
                busy        = 1'b1;
                w_rd_en     = 1'b1;
                w_addr      = W_AW'(((int'(oc_q) * IN_CHANNELS + int'(c_q)) * KERNEL_SIZE
                                     + int'(ky_q)) * KERNEL_SIZE + int'(kx_q));
                tap_valid_d = tap_in_bounds;
                if (tap_in_bounds) begin
                    in_rd_en = 1'b1;
                    in_addr  = IN_AW'(((int'(b_q) * IN_CHANNELS + int'(c_q)) * IN_HEIGHT
                                       + iy) * IN_WIDTH + ix);
                end

                // The bias read in BIAS lands on the first tap cycle and seeds
                // the accumulator; later cycles fold in the previous product.
                if (c_q == '0 && ky_q == '0 && kx_q == '0) begin
                    acc_d = b_rd_data;
                end else begin
                    acc_d = acc_q + prev_prod;
                end

                if (kx_q != K_LAST) begin
                    kx_d = kx_q + cnt_t'(1);
                end else begin
                    kx_d = '0;
                    if (ky_q != K_LAST) begin
                        ky_d = ky_q + cnt_t'(1);
                    end else begin
                        ky_d = '0;
                        if (c_q != C_LAST) begin
                            c_d = c_q + cnt_t'(1);
                        end else begin
                            c_d     = '0;
                            state_d = DRAIN;
                        end
                    end
                end
            end

            DRAIN: begin
                busy    = 1'b1;
                acc_d   = acc_q + prev_prod;
                state_d = WRITE;
            end

            WRITE: begin
                busy        = 1'b1;
                out_wr_en   = 1'b1;
                out_addr    = OUT_AW'(((int'(b_q) * OUT_CHANNELS + int'(oc_q)) * OUT_HEIGHT
                                       + int'(oy_q)) * OUT_WIDTH + int'(ox_q));
                out_wr_data = result;
                state_d     = BIAS;
                if (ox_q != OX_LAST) begin
                    ox_d = ox_q + cnt_t'(1);
                end else begin
                    ox_d = '0;
                    if (oy_q != OY_LAST) begin
                        oy_d = oy_q + cnt_t'(1);
                    end else begin
                        oy_d = '0;
                        if (oc_q != OC_LAST) begin
                            oc_d = oc_q + cnt_t'(1);
                        end else begin
                            oc_d = '0;
                            if (b_q != B_LAST) begin
                                b_d = b_q + cnt_t'(1);
                            end else begin
                                b_d     = '0;
                                state_d = DONE;
                            end
                        end
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            b_q         <= '0;
            oc_q        <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            c_q         <= '0;
            ky_q        <= '0;
            kx_q        <= '0;
            acc_q       <= '0;
            tap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            oc_q        <= oc_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            c_q         <= c_d;
            ky_q        <= ky_d;
            kx_q        <= kx_d;
            acc_q       <= acc_d;
            tap_valid_q <= tap_valid_d;
        end
    end

endmodule

// File: doc/conv2d_sequencer.md
CONV2D_SEQUENCER -- requirements
Module: conv2d_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 32, element width; BATCH_SIZE, 1; IN_CHANNELS, 1; OUT_CHANNELS, 1; IN_HEIGHT, 4; IN_WIDTH, 4; KERNEL_SIZE, 3; STRIDE, 1; PADDING, 0.
REQ-002 SHALL derive OUT_HEIGHT = (IN_HEIGHT+2*PADDING-KERNEL_SIZE)/STRIDE+1 and OUT_WIDTH likewise; each *_AW = $clog2 of the matching element count, minimum 1.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin one full convolution
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- in_rd_en / in_addr  out  1 / IN_AW  input memory read
- in_rd_data  in  DATA_WIDTH  input data, valid 1 cycle after read
- w_rd_en / w_addr  out  1 / W_AW  weight memory read
- w_rd_data  in  DATA_WIDTH  weight data, 1-cycle latency
- b_rd_en / b_addr  out  1 / B_AW  bias memory read
- b_rd_data  in  DATA_WIDTH  bias data, 1-cycle latency
- out_wr_en / out_addr / out_wr_data  out  1 / OUT_AW / DATA_WIDTH  result write

Function
REQ-004 Layouts: input ((b*IC+c)*IH+y)*IW+x; weight ((oc*IC+c)*K+ky)*K+kx; bias oc; output ((b*OC+oc)*OH+oy)*OW+ox.
REQ-005 Loop order, outermost first: b, oc, oy, ox; per output c, ky, kx.
REQ-006 FSM states IDLE, BIAS, MAC, DRAIN, WRITE, DONE.
REQ-007 IDLE: start sampled only here; start=1 -> BIAS; otherwise stay.
REQ-008 BIAS, 1 cycle: b_rd_en=1 with b_addr=oc -> MAC.
REQ-009 MAC: exactly IC*K*K cycles, one tap per cycle. Accumulator loads b_rd_data on the first MAC cycle. Each later cycle adds the product of the previous tap -> DRAIN after the last tap.
REQ-010 Tap position: iy = oy*STRIDE+ky-PADDING, ix = ox*STRIDE+kx-PADDING. If out of bounds, in_rd_en=0 and the tap adds zero; w_rd_en still asserts.
REQ-011 DRAIN, 1 cycle: add the final tap product -> WRITE.
REQ-012 WRITE, 1 cycle: out_wr_en=1 with the current out_addr and result. Then BIAS for the next output, or DONE after the last output.
REQ-013 DONE, 1 cycle: done=1 -> IDLE.
REQ-014 busy=1 in BIAS, MAC, DRAIN, WRITE; busy=0 in IDLE and DONE.
REQ-015 Arithmetic: two's-complement signed; product and sum truncated modulo 2^DATA_WIDTH.
REQ-016 Cycles per output = IC*K*K+3. With start sampled at edge 0: write n occurs in cycle n*(IC*K*K+3); done is in the cycle after the last write.
REQ-017 start while busy or done is ignored; no restart or queueing.
REQ-018 All read enables, out_wr_en and done SHALL be 0 outside the states named above.

Reset
REQ-019 rst=0 asynchronously forces IDLE and zeroes every output, counter and the accumulator.
REQ-020 Reset mid-job abandons the job: no further write, no done pulse. After release, the block waits for a new start.

Configuration
REQ-021 Macro CONV2D_SEQ_RELU_EN:
- defined: out_wr_data = 0 when the signed result is negative, else the result.
- undefined: out_wr_data = raw result; no extra logic or latency either way.

Verification
REQ-022 Defaults; input all 1, weights all 1, bias 0; start at edge 0 -> 4 writes of 0x00000009 at addr 0..3 in cycles 12, 24, 36, 48; done at cycle 49.
REQ-023 Defaults; input 1, weights 1, bias 0xFFFFFFF6 -> each write 0xFFFFFFFF without macro, 0x00000000 with CONV2D_SEQ_RELU_EN.
REQ-024 PADDING=1, 4x4 all ones, weights 1, bias 0 -> 16 writes (corners 4, edges 6, interior 9); total in_rd_en pulses = 100.
REQ-025 start pulsed again in cycle 5 of a job -> ignored; exactly 4 writes and 1 done.
REQ-026 rst low in cycle 30 -> all outputs 0 immediately; no write at cycle 36; a new start after release completes normally.
